// File: rtl/delay_pkg.sv
// Shared types and the saturating adder for the stereo delay line.
// sample_t carries one channel; frame_t packs one L/R pair.
package delay_pkg;

    localparam int SAMPLE_W = 16;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    typedef struct packed {
        sample_t l;
        sample_t r;
    } frame_t;

    // Sum at SAMPLE_W+1 bits, clamp to full-scale when the top two bits disagree
    function automatic sample_t sat_add(sample_t a, sample_t b);
        logic signed [SAMPLE_W:0] s;
        s = {a[SAMPLE_W-1], a} + {b[SAMPLE_W-1], b};
        if (s[SAMPLE_W] != s[SAMPLE_W-1])
            return s[SAMPLE_W] ? {1'b1, {(SAMPLE_W-1){1'b0}}} : {1'b0, {(SAMPLE_W-1){1'b1}}};
        return s[SAMPLE_W-1:0];
    endfunction

endpackage

// File: rtl/delay_ram.sv
// Simple dual-port frame store: one write port, one registered read port.
// No reset so it maps onto block RAM.
module delay_ram #(
    parameter int DEPTH  = 256,
    parameter int AW     = $clog2(DEPTH),
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we)
            mem[wr_addr] <= wr_data;
        if (rd_en)
            rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/stereo_delay_line.sv
// Stereo circular delay: emits the L/R pair written delay_i frames earlier, 2-cycle latency.
// Optional macro DELAY_MIX_EN: output becomes sat(dry + wet) instead of wet alone.
module stereo_delay_line
    import delay_pkg::*;
#(
    parameter int WIDTH = SAMPLE_W,
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                    sclk_in,
    input  logic                    rst,
    input  logic                    valid_i,
    input  logic signed [WIDTH-1:0] left_i,
    input  logic signed [WIDTH-1:0] right_i,
    input  logic [AW-1:0]           delay_i,
    output logic signed [WIDTH-1:0] left_o,
    output logic signed [WIDTH-1:0] right_o,
    output logic                    valid_o,
    output logic                    primed_o
);

    frame_t        in_frame;
    frame_t        dry_p1;
    frame_t        ram_q;
    frame_t        wet_p1;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] fill;
    logic [AW-1:0] rd_addr;
    logic          vld_p1;
    logic          gate_p1;
    logic          byp_p1;
    sample_t       out_l;
    sample_t       out_r;

    assign in_frame = '{l: left_i, r: right_i};
    assign rd_addr  = wr_ptr - delay_i;

    delay_ram #(
        .DEPTH  (DEPTH),
        .AW     (AW),
        .DATA_W ($bits(frame_t))
    ) u_ram (
        .clk     (sclk_in),
        .we      (valid_i),
        .wr_addr (wr_ptr),
        .wr_data (in_frame),
        .rd_en   (valid_i),
        .rd_addr (rd_addr),
        .rd_data (ram_q)
    );

    // S0 -> S1: write/read issue, pointer and fill bookkeeping
    always_ff @(posedge sclk_in or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            fill    <= '0;
            vld_p1  <= 1'b0;
            gate_p1 <= 1'b0;
            byp_p1  <= 1'b0;
        end else begin
            vld_p1 <= valid_i;
            if (valid_i) begin
                gate_p1 <= (delay_i > fill);
                byp_p1  <= (delay_i == '0);
                wr_ptr  <= wr_ptr + 1'b1;
                if (fill != AW'(DEPTH - 1))
                    fill <= fill + 1'b1;
            end
        end
    end

    always_ff @(posedge sclk_in) begin
        if (valid_i)
            dry_p1 <= in_frame;
    end

    // S1: RAM data returns; zero delay reads the pair written that cycle, not the stale word
    always_comb begin
        wet_p1 = byp_p1 ? dry_p1 : ram_q;
`ifdef DELAY_MIX_EN
        out_l = gate_p1 ? dry_p1.l : sat_add(dry_p1.l, wet_p1.l);
        out_r = gate_p1 ? dry_p1.r : sat_add(dry_p1.r, wet_p1.r);
`else
        out_l = gate_p1 ? '0 : wet_p1.l;
        out_r = gate_p1 ? '0 : wet_p1.r;
`endif
    end

    // S1 -> S2: output registers, held between valid_o pulses
    always_ff @(posedge sclk_in or negedge rst) begin
        if (!rst) begin
            valid_o  <= 1'b0;
            primed_o <= 1'b0;
            left_o   <= '0;
            right_o  <= '0;
        end else begin
            valid_o <= vld_p1;
            if (vld_p1) begin
                left_o   <= out_l;
                right_o  <= out_r;
                primed_o <= !gate_p1;
            end
        end
    end

endmodule

// File: tb/tb_stereo_delay_line.sv
// Directed bench for stereo_delay_line (DEPTH=8); expectations follow DELAY_MIX_EN when defined.
module tb_stereo_delay_line;

    localparam int W  = 16;
    localparam int D  = 8;
    localparam int AW = 3;

    logic                sclk_in;
    logic                rst;
    logic                valid_i;
    logic signed [W-1:0] left_i;
    logic signed [W-1:0] right_i;
    logic [AW-1:0]       delay_i;
    logic signed [W-1:0] left_o;
    logic signed [W-1:0] right_o;
    logic                valid_o;
    logic                primed_o;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [15:0] q_l[$];
    logic [15:0] q_r[$];
    bit          q_p[$];
    int          q_c[$];

    stereo_delay_line #(.WIDTH(W), .DEPTH(D)) dut (
        .sclk_in  (sclk_in),
        .rst      (rst),
        .valid_i  (valid_i),
        .left_i   (left_i),
        .right_i  (right_i),
        .delay_i  (delay_i),
        .left_o   (left_o),
        .right_o  (right_o),
        .valid_o  (valid_o),
        .primed_o (primed_o)
    );

    initial sclk_in = 1'b0;
    always #5 sclk_in = ~sclk_in;

    always @(posedge sclk_in) cyc++;

    always @(negedge sclk_in) begin
        if (rst && valid_o) begin
            q_l.push_back(left_o);
            q_r.push_back(right_o);
            q_p.push_back(primed_o);
            q_c.push_back(cyc);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] exp_out(logic [15:0] dry, logic [15:0] wet, bit gated);
        int s;
        s = int'($signed(dry)) + int'($signed(wet));
        if (s > 32767)  s = 32767;
        if (s < -32768) s = -32768;
`ifdef DELAY_MIX_EN
        return gated ? dry : s[15:0];
`else
        return gated ? 16'h0000 : wet;
`endif
    endfunction

    task automatic clear_q();
        q_l.delete();
        q_r.delete();
        q_p.delete();
        q_c.delete();
    endtask

    task automatic send(input logic [15:0] l, input logic [15:0] r, input logic [AW-1:0] d);
        @(negedge sclk_in);
        valid_i = 1'b1;
        left_i  = l;
        right_i = r;
        delay_i = d;
    endtask

    task automatic idle(input int n);
        @(negedge sclk_in);
        valid_i = 1'b0;
        repeat (n - 1) @(negedge sclk_in);
    endtask

    task automatic do_reset();
        @(negedge sclk_in);
        valid_i = 1'b0;
        rst     = 1'b0;
        repeat (2) @(negedge sclk_in);
        rst = 1'b1;
        clear_q();
    endtask

    initial begin
        rst     = 1'b0;
        valid_i = 1'b0;
        left_i  = '0;
        right_i = '0;
        delay_i = '0;
        repeat (3) @(negedge sclk_in);
        #1;
        check_eq("rst_left", left_o, 0);
        check_eq("rst_valid", valid_o, 0);
        check_eq("rst_primed", primed_o, 0);
        rst = 1'b1;

        // Reset while frames are in flight
        send(16'h0111, 16'h0222, 3'd0);
        send(16'h0333, 16'h0444, 3'd0);
        @(negedge sclk_in);
        valid_i = 1'b0;
        rst     = 1'b0;
        #1;
        check_eq("midrst_left", left_o, 0);
        check_eq("midrst_right", right_o, 0);
        check_eq("midrst_valid", valid_o, 0);
        check_eq("midrst_primed", primed_o, 0);
        repeat (2) @(negedge sclk_in);
        rst = 1'b1;
        clear_q();
        repeat (5) @(negedge sclk_in);
        check_eq("midrst_no_pulse", q_l.size(), 0);
        check_eq("midrst_hold_left", left_o, 0);

        // Zero delay: same-cycle write must be bypassed to the output
        do_reset();
        send(16'h1234, 16'hABCD, 3'd0);
        idle(4);
        check_eq("byp_count", q_l.size(), 1);
        if (q_l.size() >= 1) begin
            check_eq("byp_left", q_l[0], exp_out(16'h1234, 16'h1234, 1'b0));
            check_eq("byp_right", q_r[0], exp_out(16'hABCD, 16'hABCD, 1'b0));
            check_eq("byp_primed", q_p[0], 1);
        end

        // Delay 3, spaced frames 1..5, then a delay change to 1
        do_reset();
        for (int k = 1; k <= 5; k++) begin
            send(16'(k), 16'(0 - k), 3'd3);
            idle(2);
        end
        send(16'd6, 16'hFFFA, 3'd1);
        idle(4);
        check_eq("d3_count", q_l.size(), 6);
        if (q_l.size() >= 6) begin
            for (int k = 1; k <= 5; k++) begin
                logic [15:0] wl;
                logic [15:0] wr;
                bit g;
                g  = (k <= 3);
                wl = g ? 16'd0 : 16'(k - 3);
                wr = g ? 16'd0 : 16'(3 - k);
                check_eq($sformatf("d3_left_%0d", k), q_l[k-1], exp_out(16'(k), wl, g));
                check_eq($sformatf("d3_right_%0d", k), q_r[k-1], exp_out(16'(0 - k), wr, g));
                check_eq($sformatf("d3_primed_%0d", k), q_p[k-1], !g);
            end
            check_eq("dchg_left", q_l[5], exp_out(16'd6, 16'd5, 1'b0));
            check_eq("dchg_right", q_r[5], exp_out(16'hFFFA, 16'hFFFB, 1'b0));
        end

        // Delay 7 on an 8-deep buffer, 20 back-to-back frames across pointer wrap
        do_reset();
        for (int n = 0; n < 20; n++)
            send(16'(n), 16'(n + 16'h0100), 3'd7);
        idle(4);
        check_eq("wrap_count", q_l.size(), 20);
        if (q_l.size() >= 20) begin
            for (int n = 0; n < 20; n++) begin
                bit g;
                g = (n < 7);
                check_eq($sformatf("wrap_left_%0d", n), q_l[n],
                         exp_out(16'(n), g ? 16'd0 : 16'(n - 7), g));
                check_eq($sformatf("wrap_right_%0d", n), q_r[n],
                         exp_out(16'(n + 16'h0100), g ? 16'd0 : 16'(n - 7 + 16'h0100), g));
            end
        end

        // Back-to-back frames give consecutive, ordered pulses
        do_reset();
        for (int i = 0; i < 4; i++)
            send(16'(16'h0010 + i), 16'(16'h0020 + i), 3'd0);
        idle(4);
        check_eq("b2b_count", q_l.size(), 4);
        if (q_l.size() >= 4) begin
            for (int i = 0; i < 4; i++) begin
                check_eq($sformatf("b2b_left_%0d", i), q_l[i],
                         exp_out(16'(16'h0010 + i), 16'(16'h0010 + i), 1'b0));
                if (i > 0)
                    check_eq($sformatf("b2b_gap_%0d", i), q_c[i] - q_c[i-1], 1);
            end
        end

`ifdef DELAY_MIX_EN
        // Saturating mix at both rails
        do_reset();
        send(16'h2000, 16'hF000, 3'd0);
        send(16'h7000, 16'h8000, 3'd1);
        idle(4);
        check_eq("mix_count", q_l.size(), 2);
        if (q_l.size() >= 2) begin
            check_eq("mix_first_left", q_l[0], 16'h4000);
            check_eq("mix_first_right", q_r[0], 16'hE000);
            check_eq("mix_pos_sat", q_l[1], 16'h7FFF);
            check_eq("mix_neg_sat", q_r[1], 16'h8000);
        end
        do_reset();
        send(16'h1357, 16'h2468, 3'd3);
        idle(4);
        check_eq("mix_gated_count", q_l.size(), 1);
        if (q_l.size() >= 1)
            check_eq("mix_gated_dry", q_l[0], 16'h1357);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
